// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// Produces the pixel strobe, h/v counters, sync pulses, blanking, line/frame
// strobes and a frame counter. Every output comes straight from a flop, so all
// outputs change on the same clock edge.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CNT_W    = 10,
    parameter int FCNT_W   = 8
) (
    input  logic              clk_50M,
    input  logic              rst,
    input  logic              en,
    output logic              p_tick,
    output logic [CNT_W-1:0]  pixel_x,
    output logic [CNT_W-1:0]  pixel_y,
    output logic              hsync,
    output logic              vsync,
    output logic              video_on,
    output logic              line_start,
    output logic              frame_start,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

    localparam int H_SYNC_FIRST = H_ACTIVE + H_FP;
    localparam int H_SYNC_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int V_SYNC_FIRST = V_ACTIVE + V_FP;
    localparam int V_SYNC_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_next;
    logic              tick;
    logic [CNT_W-1:0]  x_next;
    logic [CNT_W-1:0]  y_next;
    logic [FCNT_W-1:0] fcnt_next;
    logic              line_wrap;
    logic              frame_wrap;
    logic              hsync_act_next;
    logic              vsync_act_next;
    logic              video_on_next;

    // Next-state of divider and raster counters; outputs decode these next values so they stay aligned
    always_comb begin
        tick       = en && (div_cnt == DIV_LAST);
        div_next   = div_cnt;
        x_next     = pixel_x;
        y_next     = pixel_y;
        fcnt_next  = frame_cnt;
        line_wrap  = 1'b0;
        frame_wrap = 1'b0;

        if (en) begin
            div_next = tick ? '0 : div_cnt + 1'b1;
        end

        if (tick) begin
            if (pixel_x == H_LAST) begin
                x_next    = '0;
                line_wrap = 1'b1;
                if (pixel_y == V_LAST) begin
                    y_next     = '0;
                    frame_wrap = 1'b1;
                    fcnt_next  = frame_cnt + 1'b1;
                end else begin
                    y_next = pixel_y + 1'b1;
                end
            end else begin
                x_next = pixel_x + 1'b1;
            end
        end

        hsync_act_next = (int'(x_next) >= H_SYNC_FIRST) && (int'(x_next) <= H_SYNC_LAST);
        vsync_act_next = (int'(y_next) >= V_SYNC_FIRST) && (int'(y_next) <= V_SYNC_LAST);
        video_on_next  = (int'(x_next) < H_ACTIVE) && (int'(y_next) < V_ACTIVE);
    end

    // State and output registers; reset wins over enable, strobes only fire on an actual wrap
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            div_cnt     <= '0;
            p_tick      <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_cnt   <= '0;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            video_on    <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= div_next;
            p_tick      <= en && (div_next == DIV_LAST);
            pixel_x     <= x_next;
            pixel_y     <= y_next;
            frame_cnt   <= fcnt_next;
            hsync       <= hsync_act_next ? H_POL : ~H_POL;
            vsync       <= vsync_act_next ? V_POL : ~V_POL;
            video_on    <= video_on_next;
            line_start  <= line_wrap;
            frame_start <= frame_wrap;
        end
    end

endmodule
